// File: rtl/preemption_timer_if.sv
// Bus between the CPU core (master) and the quantum/preemption timer (slave).
// Handshake: the core presents SetQuantum/Halt/AckInterruption as single-cycle
// strobes qualified by the current PC/NextPC; the timer answers with registered
// one-cycle pulses IntClk/IntHalt plus level outputs Cause/SavedPC/Armed/Remaining.
// There is no back-pressure: every strobe is consumed on the edge it is sampled.
interface preemption_timer_if #(
  parameter int QW = 16
);
  logic          SetQuantum;
  logic [QW-1:0] Quantum;
  logic          Halt;
  logic [10:0]   PC;
  logic [10:0]   NextPC;
  logic          AckInterruption;
  logic          IntClk;
  logic          IntHalt;
  logic [1:0]    Cause;
  logic [10:0]   SavedPC;
  logic          Armed;
  logic [QW-1:0] Remaining;
  logic [1:0]    state_dbg;

  modport master (
    output SetQuantum, Quantum, Halt, PC, NextPC, AckInterruption,
    input  IntClk, IntHalt, Cause, SavedPC, Armed, Remaining, state_dbg
  );

  modport slave (
    input  SetQuantum, Quantum, Halt, PC, NextPC, AckInterruption,
    output IntClk, IntHalt, Cause, SavedPC, Armed, Remaining, state_dbg
  );
endinterface

// File: rtl/preemption_timer.sv
// Quantum timer for time-sharing: counts user-mode cycles, raises a preemption
// pulse on expiry or a halt-trap pulse when user code executes HALT.
module preemption_timer #(
  parameter logic [10:0] KERNEL_END = 11'd256,
  parameter int          QW         = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  preemption_timer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_QUANTUM = 2'd1;
  localparam logic [1:0] CAUSE_HALT    = 2'd2;

  state_t        state_q, state_d;
  logic [QW-1:0] remaining_q, remaining_d;
  logic          int_clk_q, int_clk_d;
  logic          int_halt_q, int_halt_d;
  logic [1:0]    cause_q, cause_d;
  logic [10:0]   saved_pc_q, saved_pc_d;
  logic          armed_q, armed_d;

  logic user;
  logic trap;
  logic fire;

  // Kernel code is never charged and never trapped.
  assign user = (bus.PC >= KERNEL_END);
  assign trap = bus.Halt && user;

  // Next-state: trap, then reload, then count/expiry; Ack only clears Cause
  // when nothing new is being latched this cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    int_clk_d   = 1'b0;
    int_halt_d  = 1'b0;
    cause_d     = bus.AckInterruption ? CAUSE_NONE : cause_q;
    saved_pc_d  = saved_pc_q;
    fire        = 1'b0;

    if (trap) begin
      int_halt_d  = 1'b1;
      cause_d     = CAUSE_HALT;
      state_d     = IDLE;
      remaining_d = '0;
    end else if (bus.SetQuantum) begin
      if (bus.Quantum != '0) begin
        remaining_d = bus.Quantum;
        state_d     = COUNT;
      end else begin
        remaining_d = '0;
        state_d     = IDLE;
      end
    end else begin
      unique case (state_q)
        COUNT: begin
          if (user) begin
            if (remaining_q > QW'(1)) begin
              remaining_d = remaining_q - QW'(1);
            end else if (remaining_q == '0) begin
              // Defensive: a zero count never lingers in COUNT.
              state_d = IDLE;
            end else if (cause_q == CAUSE_NONE) begin
              fire = 1'b1;
            end else begin
              // Previous interruption not yet acknowledged: defer expiry.
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (user && (cause_q == CAUSE_NONE)) begin
            fire = 1'b1;
          end
        end
        default: ;
      endcase

      if (fire) begin
        int_clk_d   = 1'b1;
        cause_d     = CAUSE_QUANTUM;
        saved_pc_d  = bus.NextPC;
        state_d     = IDLE;
        remaining_d = '0;
      end
    end

    armed_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset drops any pulse in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      int_clk_q   <= 1'b0;
      int_halt_q  <= 1'b0;
      cause_q     <= CAUSE_NONE;
      saved_pc_q  <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      int_clk_q   <= int_clk_d;
      int_halt_q  <= int_halt_d;
      cause_q     <= cause_d;
      saved_pc_q  <= saved_pc_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.IntClk    = int_clk_q;
  assign bus.IntHalt   = int_halt_q;
  assign bus.Cause     = cause_q;
  assign bus.SavedPC   = saved_pc_q;
  assign bus.Armed     = armed_q;
  assign bus.Remaining = remaining_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/preemption_timer.md
# preemption_timer

Quantum timer and interrupt source for the processor's time-sharing support. Loaded by the set-quantum instruction, it counts clock cycles while user code runs (PC at or above the kernel boundary). It raises a one-cycle preemption pulse on expiry, or a halt-trap pulse when a user process executes HALT. It feeds the CPU top's PC-override logic (forces PC to 0), its interrupt-cause register and its PC buffer, and consumes the control unit's acknowledge.

## Interface
Parameters:
- KERNEL_END, 11'd256: first instruction address of user space; PC < KERNEL_END is kernel (never preempted, HALT is a real halt).
- QW, 16: quantum counter width.

Ports:
- Clock  in  1  system clock (CPU Clock domain).
- Reset  in  1  synchronous, active-high reset.
- SetQuantum  in  1  set-quantum instruction executing this cycle.
- Quantum  in  QW  quantum in cycles (instruction immediate [15:0]).
- Halt  in  1  HALT instruction decoded this cycle.
- PC  in  11  address of current instruction.
- NextPC  in  11  PC value the core would load next cycle.
- AckInterruption  in  1  kernel read of the cause (getInterruption).
- IntClk  out  1  one-cycle preemption pulse.
- IntHalt  out  1  one-cycle halt-trap pulse.
- Cause  out  2  latched cause: 0 none, 1 quantum, 2 halt.
- SavedPC  out  11  resume address captured at preemption.
- Armed  out  1  counter running or holding.
- Remaining  out  QW  cycles left.

## Operation
- Reset values: IntClk=0, IntHalt=0, Cause=0, SavedPC=0, Armed=0, Remaining=0.
- Define user = (PC >= KERNEL_END).
- There are three states.
  - IDLE (Armed=0).
  - COUNT (Armed=1, Remaining>0).
  - HOLD (Armed=1, Remaining=1, expiry deferred while Cause!=0).
- Load: SetQuantum with Quantum!=0 sets Remaining=Quantum, Armed=1 and enters COUNT. This holds in any state, and a reload restarts the count.
- SetQuantum with Quantum=0 sets Armed=0, Remaining=0 and enters IDLE.
- COUNT, user=1, Remaining>1: Remaining decrements by 1.
- COUNT, user=0: Remaining holds, so kernel time is not charged.
- COUNT, user=1, Remaining==1, Cause==0 is expiry. Next cycle:
  - IntClk=1 for one cycle.
  - Cause=1.
  - SavedPC=NextPC sampled in the expiry cycle.
  - Armed=0, Remaining=0, state IDLE.
- COUNT, user=1, Remaining==1, Cause!=0: enter HOLD with Remaining held at 1. HOLD fires the expiry the first cycle Cause==0 and user=1.
- Halt with user=1 is a trap, in any state. Next cycle:
  - IntHalt=1 for one cycle.
  - Cause=2.
  - Armed=0, Remaining=0, state IDLE.
  - SavedPC unchanged.
- A halt trap is not deferred by a pending Cause; it overwrites it.
- Halt with user=0: no pulse, no state change.
- Priority within one cycle:
  - SetQuantum beats expiry: reload, no IntClk.
  - Halt trap beats expiry: IntHalt only, Cause=2.
  - A new trap or expiry beats AckInterruption: Cause takes the new value.
- AckInterruption alone clears Cause to 0 on the next edge.
- IntClk and IntHalt are never high together.

## Timing
- All outputs are registered and update on posedge Clock.
- Trigger to pulse latency is 1 cycle. The pulse width is exactly 1 cycle.
- From a load with Quantum=N and continuous user execution, IntClk rises at the edge N cycles after the load edge, i.e. the N-th following edge.
- Reset asserted mid-count returns all outputs to reset values on that edge. A pulse in flight is dropped.
- The count wraps nowhere: Remaining saturates at 0 and never underflows.

## Test plan
1. Reset, then load Quantum=5 with PC=300 held.
   - Remaining steps 5,4,3,2,1.
   - IntClk pulses 1 cycle at the 5th edge after load.
   - Cause=1, SavedPC=NextPC (e.g. 301), Armed=0.
2. Load Quantum=3, then toggle PC between 100 (kernel) and 300 (user).
   - Only user cycles decrement.
   - Expiry occurs after 3 user cycles.
3. Halt with PC=300, Remaining=7.
   - IntHalt pulses next cycle, Cause=2, Armed=0, SavedPC unchanged.
   - Halt with PC=50 produces no pulse and Cause stays 0.
4. Simultaneous events:
   - Expiry and SetQuantum=10 in the same cycle: no IntClk, Remaining=10.
   - Expiry and Halt (user) in the same cycle: only IntHalt, Cause=2.
5. Cause=2 pending, Remaining reaches 1 in user: holds at 1 with no pulse.
   - Assert AckInterruption: Cause goes to 0, then IntClk fires.
   - Cause=1, on the next user cycle.
6. Load Quantum=4 and assert Reset after 2 cycles.
   - All outputs 0 on the following edge.
   - No IntClk ever appears.
